// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the PC fetch stage.
// Returns the addressed word a fixed LATENCY edges after acceptance and holds the front end stalled meanwhile.
module imem_fetch_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        wr_en_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] instr_o,
    output logic        valid_o,
    output logic        stall_o,
    output logic        misalign_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] instr_reg;
    logic        valid_reg;
    logic        stall_reg;
    logic        misalign_reg;

    logic        accept;
    logic        resp_fire;
    logic [AW-1:0] rd_idx;
    logic        rd_in_range;
    logic [31:0] rd_word;
    logic [AW-1:0] wr_idx;
    logic        wr_in_range;
    logic        wr_fire;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept    = start_i && req_i;
    assign resp_fire = (state_reg == BUSY) && (count_reg == 4'd0);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        addr_next  = addr_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    addr_next  = addr_i;
                    count_next = LOAD_COUNT;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count_reg != 4'd0) begin
                    count_next = count_reg - 4'd1;
                end else begin
                    state_next = RESP;
                end
            end
            RESP: begin
                // A request seen in the response cycle starts the next fetch immediately.
                if (accept) begin
                    addr_next  = addr_i;
                    count_next = LOAD_COUNT;
                    state_next = BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read side: the word is looked up only at the BUSY->RESP edge, so a write in the accept cycle is visible.
    assign rd_idx      = addr_reg[AW+1:2];
    assign rd_in_range = (addr_reg[31:AW+2] == '0);
    assign rd_word     = mem[rd_idx];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= IDLE;
            count_reg    <= 4'd0;
            addr_reg     <= 32'd0;
            instr_reg    <= 32'd0;
            valid_reg    <= 1'b0;
            stall_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            addr_reg     <= addr_next;
            valid_reg    <= resp_fire;
            stall_reg    <= (state_next == BUSY);
            misalign_reg <= resp_fire && (addr_reg[1:0] != 2'b00);
            if (resp_fire) begin
                instr_reg <= rd_in_range ? rd_word : 32'h0000_0000;
            end
        end
    end

    // Load port: only honoured while idle so a fetch in flight always sees stable contents.
    assign wr_idx      = wr_addr_i[AW+1:2];
    assign wr_in_range = (wr_addr_i[31:AW+2] == '0);
    assign wr_fire     = rst_i && wr_en_i && wr_in_range && (state_reg == IDLE);

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem[wr_idx] <= wr_data_i;
        end
    end

    assign instr_o    = instr_reg;
    assign valid_o    = valid_reg;
    assign stall_o    = stall_reg;
    assign misalign_o = misalign_reg;

endmodule

// File: doc/imem_fetch_responder.md
# imem_fetch_responder

Instruction-memory responder that answers the fetch requests issued by the program-counter stage of the pipelined CPU. It accepts a word address, returns the addressed instruction after a fixed, parameterised latency, and drives a registered stall signal that the PC and IF/ID registers use as their hazard/hold input while a fetch is outstanding. It also provides a write port so the bench or a loader can fill the memory before execution.

## Interface
- DEPTH_WORDS, 256: number of 32-bit instruction words stored; power of two, 4..4096.
- LATENCY, 2: clock edges from request acceptance to response; 1..15.
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  global run enable; requests are accepted only while high.
- req_i  input  1  fetch request, level; sampled on the rising edge.
- addr_i  input  32  byte address of instruction, sampled with req_i.
- wr_en_i  input  1  memory write enable (load port).
- wr_addr_i  input  32  byte address for the write; bits [1:0] ignored.
- wr_data_i  input  32  instruction word to write.
- instr_o  output  32  fetched instruction; held until the next response.
- valid_o  output  1  one-cycle pulse: instr_o carries a new response.
- stall_o  output  1  high while a fetch is outstanding; feeds PC hazard input.
- misalign_o  output  1  pulses with valid_o if the fetched address had bits [1:0] != 0.

## Operation
- States: IDLE, BUSY, RESP. Reset state IDLE.
- Accept condition: start_i && req_i, evaluated in IDLE or RESP.
- IDLE: on accept, latch addr_i, load counter with LATENCY-1, go BUSY; otherwise stay.
- BUSY: counter != 0 -> decrement, stay; counter == 0 -> go RESP, load instr_o, set valid_o.
- RESP: lasts exactly one cycle; on accept go BUSY (back-to-back fetch), else go IDLE.
- Read data: word index = latched addr[log2(DEPTH_WORDS)+1:2]; address bits above the array range (addr >= 4*DEPTH_WORDS) return 32'h0000_0000 (NOP).
- Misaligned address: bits [1:0] ignored for the read; misalign_o = 1 in the RESP cycle.
- Memory is read at the BUSY->RESP edge, not at acceptance.
- Writes: performed on the rising edge only when state is IDLE and wr_en_i = 1; ignored in BUSY/RESP; out-of-range write addresses ignored.
- Write and accept in the same IDLE cycle: both happen; the response reflects the new data if addresses match.
- start_i falling while BUSY: outstanding fetch completes normally; no new acceptance.
- Memory array is not reset; contents undefined until written.

## Timing
- Reset values: instr_o = 0, valid_o = 0, stall_o = 0, misalign_o = 0, state IDLE, counter 0.
- All outputs registered; no combinational input-to-output path.
- Request accepted at edge E0 -> stall_o = 1 from after E0 through the BUSY cycles.
- Response at edge E(LATENCY): valid_o = 1, stall_o = 0, instr_o updated, for the single RESP cycle.
- Back-to-back: accept in RESP cycle -> stall_o returns to 1 after that edge; throughput one fetch per LATENCY+1 cycles.
- valid_o and misalign_o drop after one cycle; instr_o holds its value.
- Asynchronous reset mid-BUSY: fetch aborted, no valid_o pulse, outputs to reset values immediately.

## Test plan
- Load words 0..3 with 32'h1111_1111..32'h4444_4444 via write port, LATENCY=2, request addr 32'h8 -> stall_o high 2 cycles, valid_o pulse after edge E2 with instr_o = 32'h3333_3333, misalign_o = 0.
- Hold req_i high with addr 0 then 4 -> responses 32'h1111_1111, 32'h2222_2222 spaced 3 cycles; stall_o low only in each RESP cycle.
- Request addr 32'h0000_0006 -> instr_o = 32'h2222_2222, misalign_o pulses with valid_o; addr 32'h0000_0400 (DEPTH 256) -> instr_o = 0.
- Write word 5 = 32'hDEAD_BEEF while BUSY -> ignored, later fetch of 32'h14 returns old value; same-cycle write+request in IDLE to 32'h14 -> returns 32'hDEAD_BEEF.
- Deassert rst_i during BUSY -> valid_o never pulses, stall_o = 0 immediately; after release, new request completes normally.
- start_i = 0 with req_i = 1 -> no acceptance, stall_o stays 0; start_i dropped mid-BUSY -> response still delivered.
